io_write_arbiter: RTL and testbench

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

---
 rtl/io_write_if.sv | 36 +++
 rtl/io_write_arbiter.sv | 112 +++++++++++
 tb/tb_io_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_write_if.sv
// Write-request bundle between two requesters and the IO write arbiter,
// plus the registered IO-memory write port and stdout/debug status.
interface io_write_if;
  logic        req0_valid;
  logic [31:0] req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [31:0] mem_writeaddr;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;
  logic        stdout_strobe;
  logic        stdout_busy;
  logic        grant_id;
  logic        dbg_state;
  logic        dbg_ptr;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output mem_writeaddr, mem_writedata, mem_writeenable,
    output stdout_strobe, stdout_busy, grant_id, dbg_state, dbg_ptr
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  mem_writeaddr, mem_writedata, mem_writeenable,
    input  stdout_strobe, stdout_busy, grant_id, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/io_write_arbiter.sv
// Round-robin arbiter for two IO write requesters with a stdout (word 0)
// hold-off window; the selected write is registered onto the memory port.
module io_write_arbiter #(
  parameter int unsigned STDOUT_BUSY = 16
) (
  input  logic      clk,
  input  logic      reset,
  io_write_if.slave bus
);
  // Handshake: a transfer happens in a cycle where reqN_valid && reqN_ready;
  // requesters hold valid/addr/data stable until then. Ready is combinational
  // from the valids, addresses and registered state, never both high.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} stdout_state_e;

  localparam logic [7:0] BUSY_CYCLES = 8'(STDOUT_BUSY);

  stdout_state_e state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic          ptr;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          strobe_q;
  logic          grant_q;

  logic          busy;
  logic          word0_0, word0_1;
  logic          elig0, elig1;
  logic          gnt0, gnt1;
  logic          xfer;
  logic          sel_word0;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_data;

  assign busy    = (state == BUSY);
  assign word0_0 = (bus.req0_addr[31:2] == 30'd0);
  assign word0_1 = (bus.req1_addr[31:2] == 30'd0);

  // A blocked word-0 request is simply not eligible, so it never takes the turn.
  assign elig0 = bus.req0_valid && !(word0_0 && busy);
  assign elig1 = bus.req1_valid && !(word0_1 && busy);

  assign gnt0 = !reset && elig0 && (!elig1 || (ptr == 1'b0));
  assign gnt1 = !reset && elig1 && (!elig0 || (ptr == 1'b1));
  assign xfer = gnt0 || gnt1;

  assign sel_addr  = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data  = gnt1 ? bus.req1_data : bus.req0_data;
  assign sel_word0 = gnt1 ? word0_1 : word0_0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (xfer && sel_word0) begin
          state_next = BUSY;
          cnt_next   = BUSY_CYCLES;
        end
      end
      BUSY: begin
        // cnt reaches 1 in the last busy cycle; word 0 is eligible the cycle after.
        if (cnt <= 8'd1) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ptr      <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      strobe_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      we_q     <= xfer;
      strobe_q <= xfer && sel_word0;
      if (xfer) begin
        addr_q  <= sel_addr;
        data_q  <= sel_data;
        grant_q <= gnt1;
        ptr     <= ~gnt1;
      end
    end
  end

  assign bus.req0_ready      = gnt0;
  assign bus.req1_ready      = gnt1;
  assign bus.mem_writeenable = we_q;
  assign bus.mem_writeaddr   = addr_q;
  assign bus.mem_writedata   = data_q;
  assign bus.stdout_strobe   = strobe_q;
  assign bus.stdout_busy     = busy;
  assign bus.grant_id        = grant_q;
  assign bus.dbg_state       = state;
  assign bus.dbg_ptr         = ptr;
endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter with a 4-cycle stdout window:
// round-robin, idle hold, single requester, stdout hold-off and reset abort.
module tb_io_write_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  io_write_if bus();

  io_write_arbiter #(.STDOUT_BUSY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h10; bus.req0_data = 32'h100;
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h20; bus.req1_data = 32'h200;

    // reset: readies gated, outputs cleared
    next_cycle();
    sample();
    check("rst_rdy0", bus.req0_ready, 0);
    check("rst_rdy1", bus.req1_ready, 0);
    next_cycle();
    sample();
    check("rst_we", bus.mem_writeenable, 0);
    check("rst_addr", bus.mem_writeaddr, 0);
    check("rst_data", bus.mem_writedata, 0);
    check("rst_strobe", bus.stdout_strobe, 0);
    check("rst_busy", bus.stdout_busy, 0);
    check("rst_grant", bus.grant_id, 0);
    check("rst_ptr", bus.dbg_ptr, 0);
    check("rst_state", bus.dbg_state, 0);

    // both valid every cycle: alternate 0,1,0,1 with one write per cycle
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      sample();
      if (k < 6) begin
        check("rr_rdy0", bus.req0_ready, (k % 2 == 0));
        check("rr_rdy1", bus.req1_ready, (k % 2 == 1));
        exp_q.push_back((k % 2 == 0) ? 32'h10 : 32'h20);
      end
      check("rr_we", bus.mem_writeenable, (k > 0));
      if (k > 0) begin
        exp_addr = exp_q.pop_front();
        check("rr_addr", bus.mem_writeaddr, exp_addr);
        check("rr_data", bus.mem_writedata, exp_addr << 4);
        check("rr_grant", bus.grant_id, ((k - 1) % 2 == 1));
      end
      next_cycle();
    end

    // idle for 10 cycles: nothing written, state held
    for (int i = 0; i < 10; i++) begin
      sample();
      check("idle_we", bus.mem_writeenable, 0);
      check("idle_grant", bus.grant_id, 1);
      check("idle_ptr", bus.dbg_ptr, 0);
      check("idle_addr", bus.mem_writeaddr, 32'h20);
      next_cycle();
    end

    // requester 1 alone
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h44; bus.req1_data = 32'hDEADBEEF;
    sample();
    check("r1_rdy1", bus.req1_ready, 1);
    check("r1_rdy0", bus.req0_ready, 0);
    next_cycle();
    bus.req1_valid = 1'b0;
    sample();
    check("r1_we", bus.mem_writeenable, 1);
    check("r1_addr", bus.mem_writeaddr, 32'h44);
    check("r1_data", bus.mem_writedata, 32'hDEADBEEF);
    check("r1_strobe", bus.stdout_strobe, 0);
    check("r1_grant", bus.grant_id, 1);
    check("r1_ptr", bus.dbg_ptr, 0);
    next_cycle();

    // stdout window: word-0 write at N, second word-0 write accepted at N+5
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h0; bus.req0_data = 32'h41;
    sample();
    check("so_rdy_n", bus.req0_ready, 1);
    next_cycle();
    bus.req0_addr = 32'h2; bus.req0_data = 32'h42;
    sample();
    check("so_strobe_n1", bus.stdout_strobe, 1);
    check("so_busy_n1", bus.stdout_busy, 1);
    check("so_state_n1", bus.dbg_state, 1);
    check("so_we_n1", bus.mem_writeenable, 1);
    check("so_addr_n1", bus.mem_writeaddr, 32'h0);
    check("so_data_n1", bus.mem_writedata, 32'h41);
    check("so_rdy_n1", bus.req0_ready, 0);
    next_cycle();
    for (int i = 2; i <= 4; i++) begin
      sample();
      check("so_busy_hold", bus.stdout_busy, 1);
      check("so_strobe_hold", bus.stdout_strobe, 0);
      check("so_rdy_hold", bus.req0_ready, 0);
      check("so_we_hold", bus.mem_writeenable, 0);
      next_cycle();
    end
    sample();
    check("so_busy_n5", bus.stdout_busy, 0);
    check("so_rdy_n5", bus.req0_ready, 1);
    next_cycle();
    bus.req0_valid = 1'b0;
    sample();
    check("so_strobe_n6", bus.stdout_strobe, 1);
    check("so_addr_n6", bus.mem_writeaddr, 32'h2);
    check("so_data_n6", bus.mem_writedata, 32'h42);
    check("so_busy_n6", bus.stdout_busy, 1);
    next_cycle();
    for (int i = 7; i <= 10; i++) begin
      sample();
      check("so_busy_tail", bus.stdout_busy, (i <= 9));
      next_cycle();
    end
    check("so_ptr", bus.dbg_ptr, 1);

    // non-word-0 traffic passes a blocked word-0 request during the window
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h0; bus.req1_data = 32'h55;
    sample();
    check("bp_rdy1_m", bus.req1_ready, 1);
    next_cycle();
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h0; bus.req0_data = 32'h66;
    bus.req1_addr = 32'h8; bus.req1_data = 32'h77;
    sample();
    check("bp_ptr_m1", bus.dbg_ptr, 0);
    check("bp_busy_m1", bus.stdout_busy, 1);
    check("bp_rdy0_m1", bus.req0_ready, 0);
    check("bp_rdy1_m1", bus.req1_ready, 1);
    next_cycle();
    bus.req1_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      sample();
      check("bp_rdy0_busy", bus.req0_ready, 0);
      if (i == 2) begin
        check("bp_we_m2", bus.mem_writeenable, 1);
        check("bp_addr_m2", bus.mem_writeaddr, 32'h8);
        check("bp_data_m2", bus.mem_writedata, 32'h77);
        check("bp_grant_m2", bus.grant_id, 1);
      end
      next_cycle();
    end
    sample();
    check("bp_busy_m5", bus.stdout_busy, 0);
    check("bp_rdy0_m5", bus.req0_ready, 1);
    next_cycle();
    bus.req0_valid = 1'b0;
    sample();
    check("bp_we_m6", bus.mem_writeenable, 1);
    check("bp_addr_m6", bus.mem_writeaddr, 32'h0);
    check("bp_data_m6", bus.mem_writedata, 32'h66);
    check("bp_strobe_m6", bus.stdout_strobe, 1);
    check("bp_grant_m6", bus.grant_id, 0);
    next_cycle();

    // reset right after an accepted transfer, inside a stdout window
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h30; bus.req1_data = 32'h33;
    sample();
    check("ra_rdy1", bus.req1_ready, 1);
    check("ra_busy", bus.stdout_busy, 1);
    #1;
    reset = 1'b1;
    #1;
    check("ra_rdy1_rst", bus.req1_ready, 0);
    next_cycle();
    reset = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h0; bus.req0_data = 32'h77;
    sample();
    check("ra_we", bus.mem_writeenable, 0);
    check("ra_addr", bus.mem_writeaddr, 0);
    check("ra_data", bus.mem_writedata, 0);
    check("ra_grant", bus.grant_id, 0);
    check("ra_ptr", bus.dbg_ptr, 0);
    check("ra_busy_clr", bus.stdout_busy, 0);
    check("ra_strobe", bus.stdout_strobe, 0);
    check("ra_state", bus.dbg_state, 0);
    check("ra_rdy0_word0", bus.req0_ready, 1);
    next_cycle();
    bus.req0_valid = 1'b0;
    sample();
    check("ra_strobe_after", bus.stdout_strobe, 1);
    check("ra_data_after", bus.mem_writedata, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
